// File: rtl/fx2_pkg.sv
// Shared constants for the FX2 slave-FIFO arbiter: endpoint addresses,
// flag bit positions, default sizing and the arbiter FSM encoding.
package fx2_pkg;

   // fifoadr values of the three endpoints
   localparam logic [1:0] CMD_ADDR   = 2'b00;  // EP2, host commands (OUT)
   localparam logic [1:0] REPLY_ADDR = 2'b10;  // EP6, register replies (IN)
   localparam logic [1:0] REC_ADDR   = 2'b11;  // EP8, timetag records (IN)

   // bit positions inside fx2_flags
   localparam int FLAG_CMD   = 0;  // command endpoint non-empty
   localparam int FLAG_REPLY = 1;  // reply endpoint not-full
   localparam int FLAG_REC   = 2;  // record endpoint not-full

   // default sizing
   localparam int DEF_MAX_BURST     = 512;
   localparam int DEF_FLUSH_TIMEOUT = 1024;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_SEL = 3'd1,
      ST_RD     = 3'd2,
      ST_WR_SEL = 3'd3,
      ST_WR     = 3'd4,
      ST_PKTEND = 3'd5
   } fx2_state_e;

endpackage

// File: rtl/fx2_flush_timer.sv
// Tracks whether record bytes sit uncommitted in the record endpoint and
// requests a pktend once the record source has been quiet long enough.
module fx2_flush_timer
   import fx2_pkg::*;
#(
   parameter int FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic rec_write,   // a record byte was written this cycle
   input  logic rec_commit,  // record pktend issued this cycle
   input  logic rec_valid,   // record source has a byte
   input  logic rec_flag,    // record endpoint not-full
   output logic pending,
   output logic flush_req
);

   localparam int CW = $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FLUSH_TIMEOUT);

   logic [CW-1:0] idle_cnt;

   // Pending flag: set by any record write, cleared by a record pktend
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending <= 1'b0;
      end else if (rec_write) begin
         pending <= 1'b1;
      end else if (rec_commit) begin
         pending <= 1'b0;
      end
   end

   // Saturating count of quiet cycles while bytes are pending; a new record
   // byte or an empty packet restarts it so one flush fires per packet
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt <= '0;
      end else if (rec_valid || !pending) begin
         idle_cnt <= '0;
      end else if (idle_cnt != CNT_MAX) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   assign flush_req = pending && (idle_cnt == CNT_MAX) && rec_flag;

endmodule

// File: rtl/fx2_fifo_arbiter.sv
// Owns the FX2 slave-FIFO bus and shares it between the command OUT stream,
// the register-reply IN stream and the timetag-record IN stream.
//
// Handshakes: a byte moves on a source/sink pair in exactly the cycle where
// valid and ready are both high at the rising clock edge; ready is never
// asserted without the matching bus strobe in the same cycle.
module fx2_fifo_arbiter
   import fx2_pkg::*;
#(
   parameter int MAX_BURST     = DEF_MAX_BURST,
   parameter int FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] fx2_flags,
   input  logic [7:0] fx2_fd_in,
   output logic [7:0] fx2_fd_out,
   output logic       fx2_fd_oe,
   output logic [1:0] fx2_fifoadr,
   output logic       fx2_slrd,
   output logic       fx2_slwr,
   output logic       fx2_sloe,
   output logic       fx2_pktend,
   output logic [7:0] cmd_data,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   input  logic [7:0] reply_data,
   input  logic       reply_valid,
   input  logic       reply_last,
   output logic       reply_ready,
   input  logic [7:0] rec_data,
   input  logic       rec_valid,
   output logic       rec_ready,
   output fx2_state_e dbg_state
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

   fx2_state_e state, state_nx;
   logic [1:0]    fifoadr_q, fifoadr_nx;
   logic          sel_reply_q, sel_reply_nx;  // 1 = reply source owns WR
   logic [7:0]    cmd_hold;
   logic          cmd_valid_q;
   logic [BW-1:0] burst_q;
   logic          src_valid, src_flag, wr_xfer, rd_strobe;
   logic          pending, flush_req;

   // Transfer qualifiers for the current cycle
   always_comb begin
      src_valid = sel_reply_q ? reply_valid : rec_valid;
      src_flag  = sel_reply_q ? fx2_flags[FLAG_REPLY] : fx2_flags[FLAG_REC];
      wr_xfer   = (state == ST_WR) && src_valid && src_flag;
      rd_strobe = (state == ST_RD) && fx2_flags[FLAG_CMD] && !cmd_valid_q;
   end

   // Bus and client outputs, decoded from state and qualifiers
   always_comb begin
      fx2_slrd    = !rd_strobe;
      fx2_slwr    = !wr_xfer;
      fx2_sloe    = !((state == ST_RD_SEL) || (state == ST_RD));
      fx2_fd_oe   = (state == ST_WR_SEL) || (state == ST_WR);
      fx2_pktend  = (state != ST_PKTEND);
      fx2_fifoadr = fifoadr_q;
      fx2_fd_out  = sel_reply_q ? reply_data : rec_data;
      reply_ready = wr_xfer && sel_reply_q;
      rec_ready   = wr_xfer && !sel_reply_q;
      cmd_data    = cmd_hold;
      cmd_valid   = cmd_valid_q;
      dbg_state   = state;
   end

   // Next-state: fixed-priority arbitration in IDLE, per-state exits elsewhere
   always_comb begin
      state_nx     = state;
      fifoadr_nx   = fifoadr_q;
      sel_reply_nx = sel_reply_q;
      case (state)
         ST_IDLE: begin
            if (fx2_flags[FLAG_CMD] && !cmd_valid_q) begin
               state_nx   = ST_RD_SEL;
               fifoadr_nx = CMD_ADDR;
            end else if (reply_valid && fx2_flags[FLAG_REPLY]) begin
               state_nx     = ST_WR_SEL;
               fifoadr_nx   = REPLY_ADDR;
               sel_reply_nx = 1'b1;
            end else if (rec_valid && fx2_flags[FLAG_REC]) begin
               state_nx     = ST_WR_SEL;
               fifoadr_nx   = REC_ADDR;
               sel_reply_nx = 1'b0;
            end else if (flush_req) begin
               state_nx   = ST_PKTEND;
               fifoadr_nx = REC_ADDR;
            end
         end
         ST_RD_SEL: state_nx = ST_RD;
         ST_RD: begin
            if (!fx2_flags[FLAG_CMD]) state_nx = ST_IDLE;
         end
         ST_WR_SEL: state_nx = ST_WR;
         ST_WR: begin
            if (!wr_xfer) begin
               state_nx = ST_IDLE;
            end else if (sel_reply_q && reply_last) begin
               state_nx = ST_PKTEND;
            end else if (!sel_reply_q && (burst_q == BURST_LAST)) begin
               state_nx = ST_IDLE;
            end
         end
         ST_PKTEND: state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // State, endpoint selection and source selection registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         fifoadr_q   <= CMD_ADDR;
         sel_reply_q <= 1'b0;
      end else begin
         state       <= state_nx;
         fifoadr_q   <= fifoadr_nx;
         sel_reply_q <= sel_reply_nx;
      end
   end

   // One-byte command holding register; a new read waits until it drains
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_hold    <= 8'h00;
         cmd_valid_q <= 1'b0;
      end else if (rd_strobe) begin
         cmd_hold    <= fx2_fd_in;
         cmd_valid_q <= 1'b1;
      end else if (cmd_valid_q && cmd_ready) begin
         cmd_valid_q <= 1'b0;
      end
   end

   // Record burst length, restarted at every new write grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         burst_q <= '0;
      end else if (state == ST_WR_SEL) begin
         burst_q <= '0;
      end else if (wr_xfer && !sel_reply_q) begin
         burst_q <= burst_q + 1'b1;
      end
   end

   fx2_flush_timer #(
      .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
   ) u_flush_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .rec_write  (wr_xfer && !sel_reply_q),
      .rec_commit ((state == ST_PKTEND) && (fifoadr_q == REC_ADDR)),
      .rec_valid  (rec_valid),
      .rec_flag   (fx2_flags[FLAG_REC]),
      .pending    (pending),
      .flush_req  (flush_req)
   );

endmodule

// File: tb/tb_fx2_fifo_arbiter.sv
// Bench for fx2_fifo_arbiter: FX2 endpoints and client sources are modelled
// as byte queues; every byte leaving a queue must reappear, in order, at the
// other side, and bus-protocol rules are checked every cycle.
module tb_fx2_fifo_arbiter;
   import fx2_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] fx2_flags = 3'b000;
   logic [7:0] fx2_fd_in = 8'h00;
   logic [7:0] fx2_fd_out;
   logic       fx2_fd_oe;
   logic [1:0] fx2_fifoadr;
   logic       fx2_slrd, fx2_slwr, fx2_sloe, fx2_pktend;
   logic [7:0] cmd_data;
   logic       cmd_valid;
   logic       cmd_ready = 1'b1;
   logic [7:0] reply_data = 8'h00;
   logic       reply_valid = 1'b0;
   logic       reply_last = 1'b0;
   logic       reply_ready;
   logic [7:0] rec_data = 8'h00;
   logic       rec_valid = 1'b0;
   logic       rec_ready;
   fx2_state_e dbg_state;

   fx2_fifo_arbiter dut (
      .clk(clk), .reset_n(reset_n), .fx2_flags(fx2_flags), .fx2_fd_in(fx2_fd_in),
      .fx2_fd_out(fx2_fd_out), .fx2_fd_oe(fx2_fd_oe), .fx2_fifoadr(fx2_fifoadr),
      .fx2_slrd(fx2_slrd), .fx2_slwr(fx2_slwr), .fx2_sloe(fx2_sloe),
      .fx2_pktend(fx2_pktend), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .reply_data(reply_data), .reply_valid(reply_valid),
      .reply_last(reply_last), .reply_ready(reply_ready), .rec_data(rec_data),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // endpoint and source models, scoreboards
   logic [7:0] ep2_q[$];       // host bytes waiting in EP2
   logic [8:0] rep_src_q[$];   // {last, data} waiting at reply source
   logic [7:0] rec_src_q[$];   // record bytes waiting at record source
   logic [7:0] exp_cmd_q[$];
   logic [8:0] exp_rep_q[$];
   logic [7:0] exp_rec_q[$];

   logic f1_en, f2_en, rdy_rand;
   int   errors = 0, checks = 0, cyc = 0;
   int   n_rd, n_rep_wr, n_rec_wr, n_pkt_rep, n_pkt_rec, n_replies;
   int   last_rep_wr_cyc, last_rec_wr_cyc, last_pkt_rep_cyc, last_pkt_rec_cyc;
   int   rd_at_rec, viol;
   logic last_rep_was_last, pending_model;

   // sampled outputs (taken at the falling edge)
   logic [7:0] s_fd_out, s_cmd_data;
   logic [1:0] s_adr;
   logic [2:0] s_flags;
   logic s_slrd, s_slwr, s_sloe, s_pktend, s_fd_oe;
   logic s_cmd_valid, s_cmd_ready, s_reply_ready, s_rec_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // driver: present queue heads and endpoint flags to the DUT
   task automatic drive_inputs();
      fx2_flags[0] = (ep2_q.size() != 0);
      fx2_fd_in    = (ep2_q.size() != 0) ? ep2_q[0] : 8'h00;
      fx2_flags[1] = f1_en;
      fx2_flags[2] = f2_en;
      reply_valid  = (rep_src_q.size() != 0);
      {reply_last, reply_data} = (rep_src_q.size() != 0) ? rep_src_q[0] : 9'h000;
      rec_valid    = (rec_src_q.size() != 0);
      rec_data     = (rec_src_q.size() != 0) ? rec_src_q[0] : 8'h00;
      cmd_ready    = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      ep2_q.delete(); rep_src_q.delete(); rec_src_q.delete();
      exp_cmd_q.delete(); exp_rep_q.delete(); exp_rec_q.delete();
      f1_en = 1'b1; f2_en = 1'b1; rdy_rand = 1'b0;
      n_rd = 0; n_rep_wr = 0; n_rec_wr = 0; n_pkt_rep = 0; n_pkt_rec = 0; n_replies = 0;
      last_rep_wr_cyc = -10; last_rec_wr_cyc = -10;
      last_pkt_rep_cyc = -10; last_pkt_rec_cyc = -10;
      rd_at_rec = -1; viol = 0;
      last_rep_was_last = 1'b0; pending_model = 1'b0;
      drive_inputs();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // one clock: sample at negedge, apply queue effects at posedge, redrive
   task automatic cycle();
      @(negedge clk);
      s_fd_out = fx2_fd_out; s_adr = fx2_fifoadr; s_flags = fx2_flags;
      s_slrd = fx2_slrd; s_slwr = fx2_slwr; s_sloe = fx2_sloe;
      s_pktend = fx2_pktend; s_fd_oe = fx2_fd_oe;
      s_cmd_data = cmd_data; s_cmd_valid = cmd_valid; s_cmd_ready = cmd_ready;
      s_reply_ready = reply_ready; s_rec_ready = rec_ready;
      // bus rules
      if (!s_slwr && !s_pktend) viol++;
      if (s_fd_oe && !s_sloe) viol++;
      if (!s_slrd && (s_sloe || s_fd_oe || s_adr != CMD_ADDR)) viol++;
      if (!s_slwr && s_adr == REPLY_ADDR && !s_flags[1]) viol++;
      if (!s_slwr && s_adr == REC_ADDR && !s_flags[2]) viol++;
      if (s_reply_ready && (s_slwr || s_adr != REPLY_ADDR)) viol++;
      if (s_rec_ready && (s_slwr || s_adr != REC_ADDR)) viol++;
      @(posedge clk);
      cyc++;
      if (!s_slrd) begin
         n_rd++;
         if (rd_at_rec < 0) rd_at_rec = n_rec_wr;
         if (ep2_q.size() != 0) void'(ep2_q.pop_front());
      end
      if (s_cmd_valid && s_cmd_ready) begin
         if (exp_cmd_q.size() == 0) check("cmd_spurious", 1, 0);
         else check("cmd_byte", s_cmd_data, exp_cmd_q.pop_front());
      end
      if (s_reply_ready && rep_src_q.size() != 0) void'(rep_src_q.pop_front());
      if (s_rec_ready && rec_src_q.size() != 0) void'(rec_src_q.pop_front());
      if (!s_slwr) begin
         if (s_adr == REPLY_ADDR) begin
            n_rep_wr++;
            last_rep_wr_cyc = cyc;
            if (exp_rep_q.size() == 0) begin
               check("reply_spurious", 1, 0);
            end else begin
               logic [8:0] e;
               e = exp_rep_q.pop_front();
               check("reply_byte", s_fd_out, e[7:0]);
               last_rep_was_last = e[8];
            end
         end else if (s_adr == REC_ADDR) begin
            n_rec_wr++;
            last_rec_wr_cyc = cyc;
            pending_model = 1'b1;
            if (exp_rec_q.size() == 0) check("rec_spurious", 1, 0);
            else check("rec_byte", s_fd_out, exp_rec_q.pop_front());
         end else begin
            viol++;
         end
      end
      if (!s_pktend) begin
         if (s_adr == REPLY_ADDR) begin
            if (!(last_rep_was_last && last_rep_wr_cyc == cyc - 1)) viol++;
            last_rep_was_last = 1'b0;
            n_pkt_rep++;
            last_pkt_rep_cyc = cyc;
         end else if (s_adr == REC_ADDR) begin
            if (!pending_model) viol++;
            pending_model = 1'b0;
            n_pkt_rec++;
            last_pkt_rec_cyc = cyc;
         end else begin
            viol++;
         end
      end
      #1 drive_inputs();
   endtask

   task automatic run_until_empty(input int max_cyc, input string name);
      int n;
      n = 0;
      while ((exp_cmd_q.size() + exp_rep_q.size() + exp_rec_q.size()) != 0 && n < max_cyc) begin
         cycle();
         n++;
      end
      check(name, exp_cmd_q.size() + exp_rep_q.size() + exp_rec_q.size(), 0);
   endtask

   task automatic push_cmd(input logic [7:0] b);
      ep2_q.push_back(b); exp_cmd_q.push_back(b);
   endtask
   task automatic push_rep(input logic last, input logic [7:0] b);
      rep_src_q.push_back({last, b}); exp_rep_q.push_back({last, b});
   endtask
   task automatic push_rec(input logic [7:0] b);
      rec_src_q.push_back(b); exp_rec_q.push_back(b);
   endtask

   // arbitration table: inputs seen in IDLE -> {fifoadr, sloe, fd_oe} next cycle
   typedef struct {
      logic cmd, rep, f1, rec, f2;
      logic [3:0] exp;
   } vec_t;
   vec_t vecs[7];

   logic [7:0] host_bytes[7];

   initial begin
      vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000};  // command wins
      vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1011};  // reply beats record
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111};  // reply endpoint full
      vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111};  // record only
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010};  // both IN full: stay idle
      vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010};  // nothing valid
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};  // command only
      host_bytes = '{8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h40, 8'h02};

      // reset state with busy inputs
      f1_en = 1'b1; f2_en = 1'b1; rdy_rand = 1'b0;
      ep2_q.push_back(8'h77); rep_src_q.push_back(9'h1AA); rec_src_q.push_back(8'h33);
      drive_inputs();
      #3;
      check("reset_outputs",
            {fx2_slrd, fx2_slwr, fx2_sloe, fx2_pktend, fx2_fd_oe, fx2_fifoadr,
             cmd_valid, reply_ready, rec_ready}, 11'b11110_00_000);

      // table-driven arbitration
      for (int i = 0; i < 7; i++) begin
         do_reset();
         f1_en = vecs[i].f1; f2_en = vecs[i].f2;
         if (vecs[i].cmd) ep2_q.push_back(8'h11);
         if (vecs[i].rep) rep_src_q.push_back(9'h1AB);
         if (vecs[i].rec) rec_src_q.push_back(8'hCD);
         drive_inputs();
         @(posedge clk);
         @(negedge clk);
         check($sformatf("arb_vec%0d", i), {fx2_fifoadr, fx2_sloe, fx2_fd_oe}, vecs[i].exp);
      end

      // host command sequence, then random parser back-pressure
      do_reset();
      for (int i = 0; i < 7; i++) push_cmd(host_bytes[i]);
      drive_inputs();
      run_until_empty(100, "cmd_drain");
      check("cmd_reads", n_rd, 7);
      rdy_rand = 1'b1;
      for (int i = 0; i < 20; i++) push_cmd(8'($urandom));
      run_until_empty(300, "cmd_rand_drain");
      check("cmd_rand_reads", n_rd, 27);
      check("inv_cmd", viol, 0);

      // reply AA 55 with last on 55
      do_reset();
      push_rep(1'b0, 8'hAA);
      push_rep(1'b1, 8'h55);
      drive_inputs();
      run_until_empty(50, "reply_drain");
      repeat (3) cycle();
      check("reply_writes", n_rep_wr, 2);
      check("reply_pktends", n_pkt_rep, 1);
      check("reply_pktend_cycle", last_pkt_rep_cyc - last_rep_wr_cyc, 1);
      check("inv_reply", viol, 0);

      // 600 records in one stream, command arriving mid-burst
      do_reset();
      for (int i = 0; i < 600; i++) push_rec(8'(i));
      drive_inputs();
      repeat (100) cycle();
      push_cmd(8'h3C);
      run_until_empty(1000, "rec_burst_drain");
      check("rec_burst_writes", n_rec_wr, 600);
      check("cmd_between_bursts", rd_at_rec, 512);
      check("inv_burst", viol, 0);

      // record endpoint full: records stall, replies still served
      do_reset();
      f2_en = 1'b0;
      for (int i = 0; i < 4; i++) push_rec(8'hE0 + 8'(i));
      push_rep(1'b0, 8'h12);
      push_rep(1'b1, 8'h34);
      drive_inputs();
      repeat (30) cycle();
      check("stall_rec_writes", n_rec_wr, 0);
      check("stall_reply_writes", n_rep_wr, 2);
      f2_en = 1'b1;
      run_until_empty(60, "stall_drain");
      check("stall_rec_after", n_rec_wr, 4);
      check("inv_stall", viol, 0);

      // partial packet flush after idle timeout
      do_reset();
      for (int i = 0; i < 3; i++) push_rec(8'h90 + 8'(i));
      drive_inputs();
      run_until_empty(20, "flush_drain");
      repeat (1100) cycle();
      check("flush_count", n_pkt_rec, 1);
      check("flush_delay_ok",
            (last_pkt_rec_cyc - last_rec_wr_cyc >= 1024) &&
            (last_pkt_rec_cyc - last_rec_wr_cyc <= 1030), 1);
      repeat (1100) cycle();
      check("flush_once", n_pkt_rec, 1);
      check("inv_flush", viol, 0);

      // asynchronous reset in the middle of a record write burst
      do_reset();
      for (int i = 0; i < 40; i++) push_rec(8'h40 + 8'(i));
      drive_inputs();
      repeat (10) cycle();
      check("pre_reset_writing", fx2_slwr, 1'b0);
      #1 reset_n = 1'b0;
      #1 check("async_reset_outputs", {fx2_slwr, fx2_pktend, fx2_fd_oe, rec_ready}, 4'b1100);
      pending_model = 1'b0;
      repeat (2) cycle();
      reset_n = 1'b1;
      run_until_empty(200, "reset_resume_drain");
      check("reset_rec_writes", n_rec_wr, 40);
      check("inv_reset", viol, 0);

      // random mix of all three clients with endpoint flags toggling
      do_reset();
      rdy_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) push_cmd(8'($urandom));
         if ($urandom_range(0, 11) == 0 && rep_src_q.size() < 4) begin
            int len;
            len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++) push_rep(k == len - 1, 8'($urandom));
            n_replies++;
         end
         if ($urandom_range(0, 2) == 0) push_rec(8'($urandom));
         if ($urandom_range(0, 7) == 0) f1_en = ~f1_en;
         if ($urandom_range(0, 7) == 0) f2_en = ~f2_en;
         cycle();
      end
      f1_en = 1'b1; f2_en = 1'b1;
      run_until_empty(3000, "rand_drain");
      repeat (2) cycle();
      check("rand_reply_pktends", n_pkt_rep, n_replies);
      check("inv_rand", viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
